// File: rtl/alu_issue_queue.sv
// Issue stage for the 4-bit ALU: a request FIFO feeds the ALU from its head, and the
// ALU result plus flags are captured into an output register with a valid/ready handshake.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [2:0]       in_s,
  input  logic             flush,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_s,
  input  logic [3:0]       alu_y,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_y,
  output logic             out_carry,
  output logic             out_zero,
  output logic [2:0]       out_s,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  // Entry layout: {a[3:0], b[3:0], s[2:0]}
  logic [10:0]      mem_p0 [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [PTR_W-1:0] rd_ptr_p0;
  logic [PTR_W:0]   occ_p0;
  logic [10:0]      head_p0;
  logic             vld_p0;
  logic             full_p0;
  logic             push;
  logic             issue;
  logic             drain;

  assign vld_p0   = (occ_p0 != '0);
  assign full_p0  = (occ_p0 == FULL_OCC);
  assign in_ready = !full_p0;

  // Flush wins over everything, so neither a push nor an issue may take effect with it.
  assign push  = in_valid && !full_p0 && !flush;
  assign issue = vld_p0 && (!out_valid || out_ready) && !flush;
  assign drain = out_valid && out_ready && !vld_p0 && !flush;

  assign head_p0 = mem_p0[rd_ptr_p0];
  assign alu_a   = vld_p0 ? head_p0[10:7] : 4'd0;
  assign alu_b   = vld_p0 ? head_p0[6:3]  : 4'd0;
  assign alu_s   = vld_p0 ? head_p0[2:0]  : 3'd0;

  // ---- stage p0: request FIFO ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem_p0[wr_ptr_p0] <= {in_a, in_b, in_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      occ_p0    <= '0;
    end else if (flush) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      occ_p0    <= '0;
    end else begin
      if (push) begin
        wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      end
      if (issue) begin
        rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      end
      case ({push, issue})
        2'b10:   occ_p0 <= occ_p0 + 1'b1;
        2'b01:   occ_p0 <= occ_p0 - 1'b1;
        default: occ_p0 <= occ_p0;
      endcase
    end
  end

  // ---- stage p1: result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= 4'd0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_s     <= 3'd0;
      op_count  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_y     <= alu_y;
      out_carry <= alu_carry;
      out_zero  <= alu_zero;
      out_s     <= head_p0[2:0];
      op_count  <= op_count + CNT_W'(1);
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
